// File: rtl/factor_round.sv
// Round controller for the factorization game: loads a seeded composite target, counts down
// the round timer and divides the target by prime guesses. Optional FACTOR_ROUND_PENALTY_EN
// makes every MISS also cost 3 seconds.
module factor_round #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TIME_LIMIT = 30
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [3:0] SEED,
  input  logic [3:0] GUESS,
  input  logic       SUBMIT,
  output logic [7:0] TARGET,
  output logic [5:0] TIME_LEFT,
  output logic       BUSY,
  output logic       WIN,
  output logic       LOSE,
  output logic       MISS
);

  localparam int            CW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] TICK_MAX = CW'(CLK_HZ - 1);
  localparam logic [5:0]    TL_INIT  = 6'(TIME_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PLAY, S_DIV, S_WIN, S_LOSE
  } state_t;

  state_t        state, state_d;
  logic          start_q;
  logic [CW-1:0] cnt, cnt_d;
  logic [7:0]    work, work_d, quo, quo_d, target_d;
  logic [3:0]    g, g_d;
  logic [5:0]    tl_tick, tl_d;
  logic          busy_d, win_d, lose_d, miss_d;
  logic          start_rise, running, tick, guess_ok;
  logic [7:0]    seed_val, g_ext;

  assign start_rise = START & ~start_q;
  assign running    = (state == S_PLAY) || (state == S_DIV);
  assign tick       = running && (cnt == TICK_MAX);
  assign tl_tick    = (tick && TIME_LEFT != 6'd0) ? TIME_LEFT - 6'd1 : TIME_LEFT;
  assign g_ext      = {4'b0000, g};

  always_comb begin
    case (SEED)
      4'd1:    seed_val = 8'd18;
      4'd2:    seed_val = 8'd20;
      4'd3:    seed_val = 8'd28;
      4'd4:    seed_val = 8'd30;
      4'd5:    seed_val = 8'd36;
      4'd6:    seed_val = 8'd42;
      4'd7:    seed_val = 8'd45;
      4'd8:    seed_val = 8'd60;
      4'd9:    seed_val = 8'd84;
      default: seed_val = 8'd12;
    endcase
  end

  always_comb begin
    case (GUESS)
      4'd2, 4'd3, 4'd5, 4'd7: guess_ok = 1'b1;
      default:                guess_ok = 1'b0;
    endcase
  end

  // Outputs are computed alongside the next state so they register with the transition.
  always_comb begin
    state_d  = state;
    cnt_d    = running ? (tick ? '0 : cnt + CW'(1)) : cnt;
    work_d   = work;
    quo_d    = quo;
    g_d      = g;
    target_d = TARGET;
    tl_d     = tl_tick;
    busy_d   = BUSY;
    win_d    = WIN;
    lose_d   = LOSE;
    miss_d   = 1'b0;
    if (start_rise) begin
      state_d  = S_LOAD;
      target_d = seed_val;
      tl_d     = TL_INIT;
      cnt_d    = '0;
      busy_d   = 1'b1;
      win_d    = 1'b0;
      lose_d   = 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          state_d = S_PLAY;
          cnt_d   = '0;
        end
        S_PLAY: begin
          if (TIME_LEFT == 6'd0) begin
            state_d = S_LOSE;
            lose_d  = 1'b1;
            busy_d  = 1'b0;
          end else if (SUBMIT) begin
            if (!guess_ok) begin
              miss_d = 1'b1;
            end else begin
              g_d     = GUESS;
              work_d  = TARGET;
              quo_d   = 8'd0;
              state_d = S_DIV;
            end
          end
        end
        S_DIV: begin
          if (work >= g_ext) begin
            work_d = work - g_ext;
            quo_d  = quo + 8'd1;
          end else if (work == 8'd0) begin
            target_d = quo;
            if (quo == 8'd1) begin
              state_d = S_WIN;
              win_d   = 1'b1;
              busy_d  = 1'b0;
            end else begin
              state_d = S_PLAY;
            end
          end else begin
            miss_d  = 1'b1;
            state_d = S_PLAY;
          end
        end
        default: ;
      endcase
    end
`ifdef FACTOR_ROUND_PENALTY_EN
    // Penalty stacks on top of any tick landing in the same cycle.
    if (miss_d) tl_d = (tl_d >= 6'd3) ? tl_d - 6'd3 : 6'd0;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      start_q   <= 1'b0;
      cnt       <= '0;
      work      <= 8'd0;
      quo       <= 8'd0;
      g         <= 4'd0;
      TARGET    <= 8'd0;
      TIME_LEFT <= 6'd0;
      BUSY      <= 1'b0;
      WIN       <= 1'b0;
      LOSE      <= 1'b0;
      MISS      <= 1'b0;
    end else begin
      state     <= state_d;
      start_q   <= START;
      cnt       <= cnt_d;
      work      <= work_d;
      quo       <= quo_d;
      g         <= g_d;
      TARGET    <= target_d;
      TIME_LEFT <= tl_d;
      BUSY      <= busy_d;
      WIN       <= win_d;
      LOSE      <= lose_d;
      MISS      <= miss_d;
    end
  end

endmodule

// File: tb/tb_factor_round.sv
// Directed bench for factor_round (CLK_HZ=10, TIME_LIMIT=5); observed vector is
// {TARGET, TIME_LEFT, BUSY, WIN, LOSE, MISS}.
module tb_factor_round;

`ifdef FACTOR_ROUND_PENALTY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST, START, SUBMIT;
  logic [3:0] SEED, GUESS;
  logic [7:0] TARGET;
  logic [5:0] TIME_LEFT;
  logic       BUSY, WIN, LOSE, MISS;
  logic [17:0] obs, exp;
  int n_cmp = 0;
  int n_bad = 0;

  factor_round #(.CLK_HZ(10), .TIME_LIMIT(5)) dut (
    .CLK(CLK), .RST(RST), .START(START), .SEED(SEED), .GUESS(GUESS), .SUBMIT(SUBMIT),
    .TARGET(TARGET), .TIME_LEFT(TIME_LEFT), .BUSY(BUSY), .WIN(WIN), .LOSE(LOSE), .MISS(MISS)
  );

  always #5 CLK = ~CLK;
  assign obs = {TARGET, TIME_LEFT, BUSY, WIN, LOSE, MISS};

  // Leaves START high; returns at the sample where the loaded values are visible.
  task automatic start_round(input logic [3:0] s);
    START = 1'b0;
    SEED  = s;
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
  endtask

  // Returns lat samples after the SUBMIT cycle.
  task automatic do_guess(input logic [3:0] gv, input int lat);
    GUESS  = gv;
    SUBMIT = 1'b1;
    @(negedge CLK);
    SUBMIT = 1'b0;
    repeat (lat - 1) @(negedge CLK);
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    exp = 18'd0;
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL reset: got %h want %h", obs, exp); end
    RST = 1'b0;
    start_round(0);
    @(negedge CLK);
    GUESS = 4'd2; SUBMIT = 1'b1;
    @(negedge CLK);
    SUBMIT = 1'b0;
    @(negedge CLK);
    RST = 1'b1; START = 1'b0;
    @(negedge CLK);
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL reset_mid: got %h want %h", obs, exp); end
    RST = 1'b0;
    do_guess(3, 6);
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL reset_idle_submit: got %h want %h", obs, exp); end
    start_round(13);
    exp = {8'd12, 6'd5, 4'b1000};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL seed13_maps_12: got %h want %h", obs, exp); end
  endtask

  task automatic test_win;
    start_round(0);
    exp = {8'd12, 6'd5, 4'b1000};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL load_s0: got %h want %h", obs, exp); end
    @(negedge CLK);
    do_guess(2, 7);
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL div_pending: got %h want %h", obs, exp); end
    @(negedge CLK);
    exp = {8'd6, 6'd5, 4'b1000};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL first_update_8cyc: got %h want %h", obs, exp); end
    do_guess(2, 5);
    exp = {8'd3, 6'd4, 4'b1000};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL second_update: got %h want %h", obs, exp); end
    do_guess(3, 3);
    exp = {8'd1, 6'd4, 4'b0100};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL win: got %h want %h", obs, exp); end
    repeat (12) @(negedge CLK);
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL win_hold: got %h want %h", obs, exp); end
  endtask

  task automatic test_miss;
    start_round(7);
    exp = {8'd45, 6'd5, 4'b1000};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL load_s7: got %h want %h", obs, exp); end
    @(negedge CLK);
    do_guess(2, 23);
    exp = {8'd45, 6'd3, 4'b1000};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL nondiv_pending: got %h want %h", obs, exp); end
    @(negedge CLK);
    exp = {8'd45, PEN ? 6'd0 : 6'd3, 4'b1001};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL nondiv_miss: got %h want %h", obs, exp); end
    @(negedge CLK);
    exp = PEN ? {8'd45, 6'd0, 4'b0010} : {8'd45, 6'd3, 4'b1000};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL miss_one_cycle: got %h want %h", obs, exp); end
    start_round(7);
    @(negedge CLK);
    do_guess(4, 1);
    exp = {8'd45, PEN ? 6'd2 : 6'd5, 4'b1001};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL invalid4_miss: got %h want %h", obs, exp); end
    @(negedge CLK);
    exp = {8'd45, PEN ? 6'd2 : 6'd5, 4'b1000};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL invalid4_clear: got %h want %h", obs, exp); end
    start_round(7);
    @(negedge CLK);
    do_guess(1, 1);
    exp = {8'd45, PEN ? 6'd2 : 6'd5, 4'b1001};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL guess1_miss: got %h want %h", obs, exp); end
    do_guess(5, 11);
    exp = {8'd9, PEN ? 6'd1 : 6'd4, 4'b1000};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL guess1_no_div: got %h want %h", obs, exp); end
  endtask

  task automatic test_timeout;
    start_round(9);
    exp = {8'd84, 6'd5, 4'b1000};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL load_s9: got %h want %h", obs, exp); end
    repeat (10) @(negedge CLK);
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL pre_tick: got %h want %h", obs, exp); end
    @(negedge CLK);
    exp = {8'd84, 6'd4, 4'b1000};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL first_tick: got %h want %h", obs, exp); end
    repeat (40) @(negedge CLK);
    exp = {8'd84, 6'd0, 4'b1000};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL time_zero: got %h want %h", obs, exp); end
    @(negedge CLK);
    exp = {8'd84, 6'd0, 4'b0010};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL lose: got %h want %h", obs, exp); end
    repeat (5) @(negedge CLK);
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL lose_hold: got %h want %h", obs, exp); end
  endtask

  task automatic test_restart;
    start_round(3);
    exp = {8'd28, 6'd5, 4'b1000};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL restart_after_lose: got %h want %h", obs, exp); end
    @(negedge CLK);
    do_guess(2, 16);
    exp = {8'd14, 6'd4, 4'b1000};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL held_start_no_retrig: got %h want %h", obs, exp); end
    do_guess(2, 5);
    start_round(1);
    exp = {8'd18, 6'd5, 4'b1000};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL restart_mid_div: got %h want %h", obs, exp); end
    @(negedge CLK);
    do_guess(3, 8);
    exp = {8'd6, 6'd5, 4'b1000};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL restart_div_discard: got %h want %h", obs, exp); end
  endtask

  task automatic test_tick_submit;
    start_round(0);
    repeat (50) @(negedge CLK);
    exp = {8'd12, 6'd1, 4'b1000};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL tl_one: got %h want %h", obs, exp); end
    do_guess(3, 6);
    exp = {8'd4, 6'd0, 4'b1000};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL submit_on_last_tick: got %h want %h", obs, exp); end
    @(negedge CLK);
    exp = {8'd4, 6'd0, 4'b0010};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL lose_after_div: got %h want %h", obs, exp); end
  endtask

  task automatic test_penalty;
    start_round(0);
    @(negedge CLK);
    do_guess(4, 1);
    exp = {8'd12, PEN ? 6'd2 : 6'd5, 4'b1001};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL penalty_first: got %h want %h", obs, exp); end
    do_guess(4, 1);
    exp = {8'd12, PEN ? 6'd0 : 6'd5, 4'b1001};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL penalty_second: got %h want %h", obs, exp); end
    @(negedge CLK);
    exp = PEN ? {8'd12, 6'd0, 4'b0010} : {8'd12, 6'd5, 4'b1000};
    n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL penalty_after: got %h want %h", obs, exp); end
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; SEED = 4'd0; GUESS = 4'd0; SUBMIT = 1'b0;
    test_reset;
    test_win;
    test_miss;
    test_timeout;
    test_restart;
    test_tick_submit;
    test_penalty;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
